// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//
// Contents:
//   state_t        - loader FSM states
//   FRAME_IDX_*    - position of each field inside a load frame
//   WORD_BYTES     - byte stride between consecutive instruction words
//   accepts_stream - states in which the loader takes stream words
//   frame_index    - frame field consumed by a given state
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds a trailer word and
// the CHECK state; see imem_loader.sv).
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_BASE,
    HDR_LEN,
    LOAD,
    CHECK,
    RUN,
    ERROR
  } state_t;

  // Frame layout: base address, payload word count, then the payload.
  localparam int FRAME_IDX_BASE    = 0;
  localparam int FRAME_IDX_LEN     = 1;
  localparam int FRAME_IDX_PAYLOAD = 2;

  localparam int WORD_BYTES = 4;

  // The loader is busy, and ready for stream data, in exactly these states.
  function automatic logic accepts_stream(state_t s);
    return (s == HDR_BASE) || (s == HDR_LEN) || (s == LOAD) || (s == CHECK);
  endfunction

  // First frame word a state consumes; every state from LOAD onward
  // consumes payload (or trailer) words.
  function automatic int frame_index(state_t s);
    case (s)
      HDR_BASE: return FRAME_IDX_BASE;
      HDR_LEN:  return FRAME_IDX_LEN;
      default:  return FRAME_IDX_PAYLOAD;
    endcase
  endfunction

endpackage

// File: rtl/imem_loader_fsm.sv
// Control FSM of the instruction-memory loader: state register,
// next-state logic and stream handshake decode.
//
// Ports:
//   clk, arst_n      - clock, asynchronous active-low reset
//   start            - one-cycle pulse requesting a new load
//   s_valid          - stream word valid
//   base_misaligned  - current stream word is a non word-aligned base
//   range_err        - base + 4*N (current word as N) exceeds the memory
//   len_zero         - current stream word, taken as N, is zero
//   last_word        - the pending payload word is the final one
//   trailer_ok       - trailer equals payload XOR (IMEM_LOADER_CHECKSUM_EN only)
//   state            - current state
//   next_state       - state after this clock edge
//   s_ready          - loader accepts a stream word this cycle
//   hs               - stream handshake (s_valid & s_ready)
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN.
module imem_loader_fsm
  import imem_loader_pkg::*;
(
  input  logic   clk,
  input  logic   arst_n,
  input  logic   start,
  input  logic   s_valid,
  input  logic   base_misaligned,
  input  logic   range_err,
  input  logic   len_zero,
  input  logic   last_word,
`ifdef IMEM_LOADER_CHECKSUM_EN
  input  logic   trailer_ok,
`endif
  output state_t state,
  output state_t next_state,
  output logic   s_ready,
  output logic   hs
);

  // After the last payload word the frame either ends or expects a trailer.
  state_t after_payload;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign after_payload = CHECK;
`else
  assign after_payload = RUN;
`endif

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Handshake decode and next-state logic. start is only honoured in
  // IDLE, RUN and ERROR so a load in progress cannot be disturbed.
  always_comb begin
    s_ready    = accepts_stream(state);
    hs         = s_valid && s_ready;
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = HDR_BASE;
      end
      HDR_BASE: begin
        if (hs) next_state = base_misaligned ? ERROR : HDR_LEN;
      end
      HDR_LEN: begin
        if (hs) begin
          if (range_err)     next_state = ERROR;
          else if (len_zero) next_state = after_payload;
          else               next_state = LOAD;
        end
      end
      LOAD: begin
        if (hs && last_word) next_state = after_payload;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (hs) next_state = trailer_ok ? RUN : ERROR;
      end
`endif
      RUN, ERROR: begin
        if (start) next_state = HDR_BASE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader for the five-stage RISC-V core. Receives a framed
// stream (base byte address, payload count N, N payload words) and
// writes the payload into instruction memory through the core's external
// write port, holding the core disabled until the image is complete.
//
// Parameters:
//   IMEM_BYTES - instruction memory capacity in bytes
//   ADDR_W     - width of addr_ext
//
// Ports:
//   clk, arst_n - clock, asynchronous active-low reset
//   start       - one-cycle pulse, begins a new load
//   s_valid     - stream word valid
//   s_data      - stream word
//   s_ready     - loader accepts s_data this cycle
//   addr_ext    - instruction memory byte address
//   wen_ext     - instruction memory write strobe (one cycle per word)
//   wdata_ext   - instruction word to write
//   cpu_enable  - core enable
//   busy        - load in progress
//   error       - sticky load error, cleared by the next start
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When defined, a trailer
// word equal to the XOR of all payload words follows the payload and is
// checked before the core is released; the trailer is never written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_BYTES = 512,
  parameter int ADDR_W     = 64
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] addr_ext,
  output logic              wen_ext,
  output logic [31:0]       wdata_ext,
  output logic              cpu_enable,
  output logic              busy,
  output logic              error
);

  state_t            state;
  state_t            next_state;
  logic              hs;
  logic              base_hs;
  logic              len_hs;
  logic              load_hs;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       remaining;
  logic [ADDR_W+1:0] frame_end;
  logic              range_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       xor_acc;
`endif

  assign base_hs = hs && (state == HDR_BASE);
  assign len_hs  = hs && (state == HDR_LEN);
  assign load_hs = hs && (state == LOAD);

  // cur_addr still holds the base while the length word is on s_data.
  // The end address is formed two bits wider than ADDR_W so a huge N
  // cannot wrap around and look legal.
  assign frame_end = (ADDR_W+2)'(cur_addr) + ((ADDR_W+2)'(s_data) << 2);
  assign range_err = frame_end > (ADDR_W+2)'(IMEM_BYTES);

  imem_loader_fsm u_fsm (
    .clk             (clk),
    .arst_n          (arst_n),
    .start           (start),
    .s_valid         (s_valid),
    .base_misaligned (s_data[1:0] != 2'b00),
    .range_err       (range_err),
    .len_zero        (s_data == 32'd0),
    .last_word       (remaining == 32'd1),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .trailer_ok      (s_data == xor_acc),
`endif
    .state           (state),
    .next_state      (next_state),
    .s_ready         (s_ready),
    .hs              (hs)
  );

  // Address and remaining-count counters (plus the payload XOR when the
  // checksum is built in). The address is loaded from the base word and
  // advances one word per accepted payload word.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cur_addr  <= '0;
      remaining <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_acc   <= '0;
`endif
    end else begin
      if (base_hs) begin
        cur_addr <= ADDR_W'(s_data);
      end else if (load_hs) begin
        cur_addr <= cur_addr + ADDR_W'(WORD_BYTES);
      end
      if (len_hs) begin
        remaining <= s_data;
      end else if (load_hs) begin
        remaining <= remaining - 32'd1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (len_hs) begin
        xor_acc <= '0;
      end else if (load_hs) begin
        xor_acc <= xor_acc ^ s_data;
      end
`endif
    end
  end

  // Registered outputs. cpu_enable only rises once RUN has been held for
  // a cycle, so the final write strobe lands before the core fetches; a
  // start while running drops it on the very next cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      addr_ext   <= '0;
      wen_ext    <= 1'b0;
      wdata_ext  <= '0;
      cpu_enable <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      wen_ext <= load_hs;
      if (load_hs) begin
        addr_ext  <= cur_addr;
        wdata_ext <= s_data;
      end
      cpu_enable <= (state == RUN) && (next_state == RUN);
      busy       <= accepts_stream(next_state);
      error      <= (next_state == ERROR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking testbench for imem_loader. A cycle table covers the basic
// back-to-back load; hand-written sequences cover restart, stalls, range
// and alignment errors, empty frames, mid-load reset and (when
// IMEM_LOADER_CHECKSUM_EN is defined) trailer checking.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int IMEM_BYTES = 512;
  localparam int ADDR_W     = 64;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              start;
  logic              s_valid;
  logic [31:0]       s_data;
  logic              s_ready;
  logic [ADDR_W-1:0] addr_ext;
  logic              wen_ext;
  logic [31:0]       wdata_ext;
  logic              cpu_enable;
  logic              busy;
  logic              error;

  int checks = 0;
  int errors = 0;

  typedef logic [31:0] word_q_t[$];

  typedef struct {
    logic        start;
    logic        valid;
    logic [31:0] data;
    logic        ready;
    logic        wen;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic        cpu;
    logic        busy;
    logic        err;
  } vec_t;

  logic [63:0] wr_addr[$];
  logic [31:0] wr_data[$];

  always #5 clk = ~clk;

  imem_loader #(
    .IMEM_BYTES (IMEM_BYTES),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .addr_ext   (addr_ext),
    .wen_ext    (wen_ext),
    .wdata_ext  (wdata_ext),
    .cpu_enable (cpu_enable),
    .busy       (busy),
    .error      (error)
  );

  // Record every memory write strobe, sampled on the falling edge.
  always @(negedge clk) begin
    if (wen_ext === 1'b1) begin
      wr_addr.push_back(addr_ext);
      wr_data.push_back(wdata_ext);
    end
  end

  // Hard stop in case the bench itself wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic st, input logic v, input logic [31:0] d);
    @(negedge clk);
    start   = st;
    s_valid = v;
    s_data  = d;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] xorAll(input word_q_t w);
    logic [31:0] x = '0;
    foreach (w[i]) x = x ^ w[i];
    return x;
  endfunction

  function automatic word_q_t makeFrame(input logic [31:0] base, input word_q_t payload);
    word_q_t f;
    f.push_back(base);
    f.push_back(32'(payload.size()));
    foreach (payload[i]) f.push_back(payload[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
    f.push_back(xorAll(payload));
`endif
    return f;
  endfunction

  task automatic streamWords(input word_q_t w);
    foreach (w[i]) applyStimulus(1'b0, 1'b1, w[i]);
  endtask

  task automatic waitCpuEnable(input string name, input int budget);
    for (int i = 0; i < budget && cpu_enable !== 1'b1; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
    end
    checkOutput(name, 64'(cpu_enable), 64'd1);
  endtask

  task automatic checkWrites(input string name, input logic [63:0] base, input word_q_t exp);
    checkOutput({name, ".count"}, 64'(wr_addr.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < wr_addr.size(); i++) begin
      checkOutput($sformatf("%s.addr%0d", name, i), wr_addr[i], base + 64'(4 * i));
      checkOutput($sformatf("%s.data%0d", name, i), 64'(wr_data[i]), 64'(exp[i]));
    end
  endtask

  function automatic vec_t mk(logic st, logic v, logic [31:0] d, logic rdy, logic wen,
                              logic [63:0] a, logic [31:0] wd, logic cpu, logic bsy, logic err);
    vec_t r;
    r.start = st;  r.valid = v;   r.data = d;
    r.ready = rdy; r.wen = wen;   r.addr = a; r.wdata = wd;
    r.cpu = cpu;   r.busy = bsy;  r.err = err;
    return r;
  endfunction

  initial begin
    vec_t    tbl[$];
    word_q_t payload;
    word_q_t words;
    logic [31:0] w0 = 32'h00500093;
    logic [31:0] w1 = 32'h00A00113;
    logic [31:0] w2 = 32'h002081B3;
    logic [31:0] pa = 32'h11111111;
    logic [31:0] pb = 32'h22222222;

    // Back-to-back load of three instructions at address 0.
    tbl.push_back(mk(1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h0,        1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 32'd3,        1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, w0,           1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, w1,           1, 1, 64'h0, w0, 0, 1, 0));
    tbl.push_back(mk(0, 1, w2,           1, 1, 64'h4, w1, 0, 1, 0));
`ifdef IMEM_LOADER_CHECKSUM_EN
    tbl.push_back(mk(0, 1, 32'h00D08033, 1, 1, 64'h8, w2, 0, 1, 0));
    tbl.push_back(mk(0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0));
`else
    tbl.push_back(mk(0, 1, 32'hDEADBEEF, 0, 1, 64'h8, w2, 0, 0, 0));
`endif
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 0, 0, 1, 0, 0));

    // Reset values.
    start = 1'b0; s_valid = 1'b0; s_data = '0;
    arst_n = 1'b1;
    #2 arst_n = 1'b0;
    #1;
    checkOutput("rst.ready", 64'(s_ready),    64'd0);
    checkOutput("rst.wen",   64'(wen_ext),    64'd0);
    checkOutput("rst.addr",  addr_ext,        64'd0);
    checkOutput("rst.wdata", 64'(wdata_ext),  64'd0);
    checkOutput("rst.cpu",   64'(cpu_enable), 64'd0);
    checkOutput("rst.busy",  64'(busy),       64'd0);
    checkOutput("rst.error", 64'(error),      64'd0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].start, tbl[i].valid, tbl[i].data);
      checkOutput($sformatf("t1[%0d].ready", i), 64'(s_ready),    64'(tbl[i].ready));
      checkOutput($sformatf("t1[%0d].wen", i),   64'(wen_ext),    64'(tbl[i].wen));
      checkOutput($sformatf("t1[%0d].cpu", i),   64'(cpu_enable), 64'(tbl[i].cpu));
      checkOutput($sformatf("t1[%0d].busy", i),  64'(busy),       64'(tbl[i].busy));
      checkOutput($sformatf("t1[%0d].error", i), 64'(error),      64'(tbl[i].err));
      if (tbl[i].wen) begin
        checkOutput($sformatf("t1[%0d].addr", i),  addr_ext,        tbl[i].addr);
        checkOutput($sformatf("t1[%0d].wdata", i), 64'(wdata_ext), 64'(tbl[i].wdata));
      end
    end

    // Restart from RUN, then a stalled stream: base 0x10, N=2.
    wr_addr.delete(); wr_data.delete();
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h10);
    checkOutput("restart.cpu_drop", 64'(cpu_enable), 64'd0);
    checkOutput("restart.busy",     64'(busy),       64'd1);
    applyStimulus(1'b0, 1'b1, 32'd2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'(i % 2), (i < 2) ? pa : pb);
      checkOutput($sformatf("stall[%0d].ready", i), 64'(s_ready), 64'd1);
      checkOutput($sformatf("stall[%0d].wen", i),   64'(wen_ext), 64'(i == 2));
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(1'b0, 1'b1, pa ^ pb);
`endif
    waitCpuEnable("stall.cpu", 10);
    payload = {pa, pb};
    checkWrites("stall", 64'h10, payload);

    // Range error: 0x1F0 + 4*5 = 0x204 > 0x200.
    wr_addr.delete(); wr_data.delete();
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h1F0);
    applyStimulus(1'b0, 1'b1, 32'd5);
    applyStimulus(1'b0, 1'b1, 32'h12345678);
    checkOutput("range.error", 64'(error),      64'd1);
    checkOutput("range.busy",  64'(busy),       64'd0);
    checkOutput("range.ready", 64'(s_ready),    64'd0);
    checkOutput("range.cpu",   64'(cpu_enable), 64'd0);
    repeat (3) applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("range.sticky", 64'(error),        64'd1);
    checkOutput("range.writes", 64'(wr_addr.size()), 64'd0);

    // Alignment error: base 0x2.
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h2);
    checkOutput("align.cleared", 64'(error), 64'd0);
    checkOutput("align.busy",    64'(busy),  64'd1);
    applyStimulus(1'b0, 1'b1, 32'd5);
    checkOutput("align.error", 64'(error),   64'd1);
    checkOutput("align.ready", 64'(s_ready), 64'd0);

    // Empty frame: N=0.
    wr_addr.delete(); wr_data.delete();
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h40);
    applyStimulus(1'b0, 1'b1, 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(1'b0, 1'b1, 32'd0);
    checkOutput("empty.trailer_ready", 64'(s_ready), 64'd1);
`endif
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("empty.cpu_early", 64'(cpu_enable), 64'd0);
    checkOutput("empty.busy",      64'(busy),       64'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("empty.cpu", 64'(cpu_enable), 64'd1);
    checkOutput("empty.writes", 64'(wr_addr.size()), 64'd0);

    // Reset after 2 of 4 payload words, then a complete reload.
    applyStimulus(1'b1, 1'b0, 32'h0);
    words = {32'h0, 32'd4, 32'hA0A0A0A0, 32'hB1B1B1B1};
    streamWords(words);
    @(negedge clk);
    arst_n = 1'b0; s_valid = 1'b0;
    #1;
    checkOutput("abort.wen",   64'(wen_ext),    64'd0);
    checkOutput("abort.addr",  addr_ext,        64'd0);
    checkOutput("abort.wdata", 64'(wdata_ext),  64'd0);
    checkOutput("abort.cpu",   64'(cpu_enable), 64'd0);
    checkOutput("abort.busy",  64'(busy),       64'd0);
    checkOutput("abort.ready", 64'(s_ready),    64'd0);
    repeat (2) @(negedge clk);
    checkOutput("abort.cpu_held", 64'(cpu_enable), 64'd0);
    arst_n = 1'b1;
    wr_addr.delete(); wr_data.delete();
    applyStimulus(1'b1, 1'b0, 32'h0);
    payload = {32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F, 32'hF0F0F0F0};
    streamWords(makeFrame(32'h20, payload));
    waitCpuEnable("reload.cpu", 10);
    checkWrites("reload", 64'h20, payload);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Trailer match releases the core; the trailer is not written.
    wr_addr.delete(); wr_data.delete();
    applyStimulus(1'b1, 1'b0, 32'h0);
    words = {32'h80, 32'd2, 32'h1, 32'h2, 32'h3};
    streamWords(words);
    waitCpuEnable("csum_ok.cpu", 10);
    payload = {32'h1, 32'h2};
    checkWrites("csum_ok", 64'h80, payload);

    // Trailer mismatch ends in ERROR with the core held.
    applyStimulus(1'b1, 1'b0, 32'h0);
    words = {32'h80, 32'd2, 32'h1, 32'h2, 32'h4};
    streamWords(words);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("csum_bad.error", 64'(error), 64'd1);
    repeat (4) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("csum_bad.cpu", 64'(cpu_enable), 64'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
